tick_timer_arbiter: RTL

Shares one down-counting timer between NUM_REQ requesters. Each requester asks for a delay measured in ticks. The tick is a one-cycle enable pulse, normally the zero output of a clock-divider downcounter.
The block grants the timer round-robin, loads the requester's period, and counts down on each tick. It then pulses that requester's done bit and releases the timer.
It sits between the clock divider and control FSMs that need delays, such as display refresh and debounce, so each of them does not need its own counter.

---
 rtl/tick_timer_pkg.sv | 35 +++
 rtl/tick_timer_core.sv | 29 ++
 rtl/tick_timer_arbiter.sv | 119 +++++++++++
 3 files changed

// File: rtl/tick_timer_pkg.sv
// Shared types and the round-robin selector for the tick timer arbiter.
package tick_timer_pkg;

  localparam int MAX_REQ = 8;
  localparam int IDX_W   = 3;

  typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } pick_t;

  // First asserted request scanning upward from last+1, wrapping at num_req.
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                    input logic [IDX_W-1:0]   last,
                                    input int                 num_req);
    pick_t            p;
    int               pos;
    logic [IDX_W-1:0] ix;
    p.valid = 1'b0;
    p.idx   = '0;
    for (int k = 1; k <= MAX_REQ; k++) begin
      pos = int'(last) + k;
      if (pos >= num_req) pos = pos - num_req;
      ix = pos[IDX_W-1:0];
      if (k <= num_req && !p.valid && req[ix]) begin
        p.valid = 1'b1;
        p.idx   = ix;
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/tick_timer_core.sv
// Shared down-counter: load, decrement on tick, terminal detect at count==1.
module tick_timer_core
  import tick_timer_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             tick,
  input  logic             clear,
  output logic [WIDTH-1:0] count,
  output logic             expire
);

  always_ff @(posedge clk) begin
    if (reset || clear)
      count <= '0;
    else if (load)
      count <= load_value;
    else if (tick && count != '0)
      count <= count - WIDTH'(1);
  end

  // Compare against 1 so the register lands on 0 without ever wrapping.
  assign expire = tick && (count == WIDTH'(1));

endmodule

// File: rtl/tick_timer_arbiter.sv
// Round-robin owner of one shared tick timer; pulses done to the owner on expiry.
module tick_timer_arbiter
  import tick_timer_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     tick,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] req_period,
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       done,
  output logic                     busy,
  output logic [WIDTH-1:0]         count
);

  state_t             state, state_n;
  logic [IDX_W-1:0]   last, last_n;
  logic [IDX_W-1:0]   owner, owner_n;
  logic [NUM_REQ-1:0] grant_n, done_n;
  logic [MAX_REQ-1:0] req_pad;
  logic [WIDTH-1:0]   per [MAX_REQ];
  logic [WIDTH-1:0]   load_value;
  logic               load, clear, core_tick, expire;
  pick_t              pick;

  always_comb begin
    req_pad = '0;
    req_pad[NUM_REQ-1:0] = req;
  end

  for (genvar i = 0; i < MAX_REQ; i++) begin : g_per
    if (i < NUM_REQ) begin : g_used
      assign per[i] = req_period[i*WIDTH +: WIDTH];
    end else begin : g_pad
      assign per[i] = '0;
    end
  end

  assign pick       = rr_pick(req_pad, last, NUM_REQ);
  assign load_value = (per[pick.idx] == '0) ? WIDTH'(1) : per[pick.idx];
  assign busy       = (state != IDLE);

  always_comb begin
    state_n   = state;
    last_n    = last;
    owner_n   = owner;
    grant_n   = grant;
    done_n    = '0;
    load      = 1'b0;
    clear     = 1'b0;
    core_tick = 1'b0;
    unique case (state)
      IDLE: begin
        grant_n = '0;
        if (pick.valid) begin
          load    = 1'b1;
          owner_n = pick.idx;
          grant_n = NUM_REQ'(1) << pick.idx;
          state_n = COUNT;
        end
      end
      COUNT: begin
        // Abort outranks a terminal tick in the same cycle.
        if (!req_pad[owner]) begin
          clear   = 1'b1;
          grant_n = '0;
          last_n  = owner;
          state_n = IDLE;
        end else begin
          core_tick = tick;
          if (expire) begin
            done_n  = grant;
            state_n = DONE;
          end
        end
      end
      DONE: begin
        grant_n = '0;
        last_n  = owner;
        state_n = IDLE;
      end
      default: begin
        grant_n = '0;
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      last  <= IDX_W'(NUM_REQ - 1);
      owner <= '0;
      grant <= '0;
      done  <= '0;
    end else begin
      state <= state_n;
      last  <= last_n;
      owner <= owner_n;
      grant <= grant_n;
      done  <= done_n;
    end
  end

  tick_timer_core #(.WIDTH(WIDTH)) u_core (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .load_value (load_value),
    .tick       (core_tick),
    .clear      (clear),
    .count      (count),
    .expire     (expire)
  );

endmodule
